// File: rtl/fmul_issue.sv
// fmul_issue: issue/retire sequencer in front of the FP multiply stage.
// Special operands resolve locally; normal results are range-clamped.
module fmul_issue #(
  parameter int MUL_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_enable,
  input  logic [31:0]      mul_out,
  input  logic [31:0]      mul_debug,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic [3:0]       resp_flags
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]       r_cnt;
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;
  logic [31:0]      r_result;
  logic [3:0]       r_flags;
  logic [TAG_W-1:0] r_tag;

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic        w_ma_nz;
  logic        w_mb_nz;
  logic        w_sign_in;
  logic        w_a_max;
  logic        w_b_max;
  logic        w_a_min;
  logic        w_b_min;
  logic        w_is_nan;
  logic        w_is_inf;
  logic        w_is_zero;
  logic        w_special;
  logic [31:0] w_spec_res;
  logic [3:0]  w_spec_flags;

  logic signed [15:0] w_x;
  logic        w_sign_run;
  logic        w_ovf;
  logic        w_unf;
  logic        w_last;
  logic [31:0] w_cap_res;
  logic [3:0]  w_cap_flags;
  logic        w_unused_dbg;

  assign w_ea      = req_a[30:23];
  assign w_eb      = req_b[30:23];
  assign w_ma_nz   = |req_a[22:0];
  assign w_mb_nz   = |req_b[22:0];
  assign w_sign_in = req_a[31] ^ req_b[31];
  assign w_a_max   = (w_ea == 8'hFF);
  assign w_b_max   = (w_eb == 8'hFF);
  assign w_a_min   = (w_ea == 8'h00);
  assign w_b_min   = (w_eb == 8'h00);

  // Classes are made mutually exclusive so the decoder can be unique.
  assign w_is_nan  = (w_a_max & w_ma_nz)
                   | (w_b_max & w_mb_nz)
                   | (w_a_max & w_b_min)
                   | (w_b_max & w_a_min);
  assign w_is_inf  = (w_a_max | w_b_max) & ~w_is_nan;
  assign w_is_zero = (w_a_min | w_b_min) & ~w_a_max & ~w_b_max;
  assign w_special = w_is_nan | w_is_inf | w_is_zero;

  // Special-operand result and flag decode
  always_comb begin
    w_spec_res   = 32'd0;
    w_spec_flags = 4'd0;
    unique case (1'b1)
      w_is_nan: begin
        w_spec_res   = 32'h7FC0_0000;
        w_spec_flags = 4'b0100;
      end
      w_is_inf: begin
        w_spec_res   = {w_sign_in, 8'hFF, 23'd0};
        w_spec_flags = 4'b0010;
      end
      w_is_zero: begin
        w_spec_res   = {w_sign_in, 31'd0};
        w_spec_flags = 4'b0001;
      end
      default: begin
        w_spec_res   = 32'd0;
        w_spec_flags = 4'd0;
      end
    endcase
  end

  assign w_x          = $signed(mul_debug[15:0]);
  assign w_unused_dbg = ^mul_debug[31:16];
  assign w_sign_run   = r_mul_a[31] ^ r_mul_b[31];
  assign w_ovf        = (w_x >= 16'sd255);
  assign w_unf        = (w_x <= 16'sd0);
  assign w_last       = (r_state == WAIT) && (r_cnt == 4'd1);

  // Exponent range clamp on the multiplier result
  always_comb begin
    w_cap_res   = mul_out;
    w_cap_flags = 4'd0;
    unique case (1'b1)
      w_ovf: begin
        w_cap_res   = {w_sign_run, 8'hFF, 23'd0};
        w_cap_flags = 4'b1010;
      end
      w_unf: begin
        w_cap_res   = {w_sign_run, 31'd0};
        w_cap_flags = 4'b1001;
      end
      default: begin
        w_cap_res   = mul_out;
        w_cap_flags = 4'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = w_special ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (w_last) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand latch, latency counter and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_mul_a  <= 32'd0;
      r_mul_b  <= 32'd0;
      r_result <= 32'd0;
      r_flags  <= 4'd0;
      r_tag    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tag <= req_tag;
            if (w_special) begin
              r_result <= w_spec_res;
              r_flags  <= w_spec_flags;
            end else begin
              r_mul_a <= req_a;
              r_mul_b <= req_b;
            end
          end
        end
        ISSUE: begin
          r_cnt <= 4'(MUL_LATENCY);
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            r_result <= w_cap_res;
            r_flags  <= w_cap_flags;
          end
        end
        RESP: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign mul_enable  = (r_state == ISSUE) || (r_state == WAIT);
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign resp_result = r_result;
  assign resp_flags  = r_flags;
  assign resp_tag    = r_tag;

endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue: two instances (latency 1 and 3) against a
// transaction-level model plus a latency-faithful multiplier stub.
module tb_fmul_issue;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       mul_enable;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][31:0] mul_a;
  logic [1:0][31:0] mul_b;
  logic [1:0][31:0] mul_out;
  logic [1:0][31:0] mul_debug;
  logic [1:0][31:0] resp_result;
  logic [1:0][3:0]  req_tag;
  logic [1:0][3:0]  resp_tag;
  logic [1:0][3:0]  resp_flags;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input int id, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL u%0d %s: got %0h want %0h", id, nm, act, exp);
    end
  endtask

  // Truncating IEEE multiply; returns {unclamped exponent, packed result}.
  function automatic logic [47:0] fmul_model(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int x;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    x = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      x = x + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {x[15:0], a[31] ^ b[31], x[7:0], m};
  endfunction

  // Expected response: {special, flags, result}.
  function automatic logic [36:0] exp_op(input logic [31:0] a,
                                         input logic [31:0] b);
    int ea;
    int eb;
    int x;
    logic s;
    logic [47:0] w;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s = a[31] ^ b[31];
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
      return {1'b1, 4'b0100, 32'h7FC00000};
    if (ea == 255 || eb == 255)
      return {1'b1, 4'b0010, s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0)
      return {1'b1, 4'b0001, s, 31'd0};
    w = fmul_model(a, b);
    x = int'($signed(w[47:32]));
    if (x >= 255) return {1'b0, 4'b1010, s, 8'hFF, 23'd0};
    if (x <= 0) return {1'b0, 4'b1001, s, 31'd0};
    return {1'b0, 4'b0000, w[31:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 1 : 3;

    fmul_issue #(.MUL_LATENCY(L), .TAG_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .req_tag    (req_tag[g]),
      .mul_a      (mul_a[g]),
      .mul_b      (mul_b[g]),
      .mul_enable (mul_enable[g]),
      .mul_out    (mul_out[g]),
      .mul_debug  (mul_debug[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_result(resp_result[g]),
      .resp_tag   (resp_tag[g]),
      .resp_flags (resp_flags[g])
    );

    // Multiplier stub: output is wrong until L edges of enable.
    int mcnt;
    logic [47:0] mw;
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mcnt <= 0;
      else if (!mul_enable[g]) mcnt <= 0;
      else if (mcnt < 30) mcnt <= mcnt + 1;
    end
    assign mw = fmul_model(mul_a[g], mul_b[g]);
    assign mul_out[g] = (mcnt >= L) ? mw[31:0] : ~mw[31:0];
    assign mul_debug[g] = (mcnt >= L) ? {16'hA5A5, mw[47:32]}
                                      : 32'h5A5A0064;

    // Transaction model: busy flag and edges since acceptance.
    bit busy = 1'b0;
    int k = 0;
    int rk;
    logic [31:0] xa = '0;
    logic [31:0] xb = '0;
    logic [3:0]  xtag = '0;
    logic [36:0] xe;
    assign xe = exp_op(xa, xb);
    always_comb rk = xe[36] ? 0 : L + 1;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        busy <= 1'b0;
      end else if (!busy) begin
        if (req_valid[g]) begin
          busy <= 1'b1;
          k <= 0;
          xa <= req_a[g];
          xb <= req_b[g];
          xtag <= req_tag[g];
        end
      end else if (k >= rk && resp_ready[g]) begin
        busy <= 1'b0;
      end else begin
        k <= k + 1;
      end
    end

    always @(negedge clk) begin
      chk(g, "req_ready", 64'(req_ready[g]), 64'(!busy));
      chk(g, "resp_valid", 64'(resp_valid[g]), 64'(busy && k >= rk));
      chk(g, "mul_enable", 64'(mul_enable[g]),
          64'(busy && !xe[36] && k <= L));
      if (busy && !xe[36] && k <= L) begin
        chk(g, "mul_a", 64'(mul_a[g]), 64'(xa));
        chk(g, "mul_b", 64'(mul_b[g]), 64'(xb));
      end
      if (busy && k >= rk) begin
        chk(g, "resp_result", 64'(resp_result[g]), 64'(xe[31:0]));
        chk(g, "resp_flags", 64'(resp_flags[g]), 64'(xe[35:32]));
        chk(g, "resp_tag", 64'(resp_tag[g]), 64'(xtag));
      end
    end
  end

  task automatic go(input int k, input logic [31:0] a,
                    input logic [31:0] b, input logic [3:0] t,
                    output int lat, output int en,
                    output logic [31:0] r, output logic [3:0] f,
                    output logic [3:0] tg);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk(k, "ready_wait", 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_a[k] = a;
    req_b[k] = b;
    req_tag[k] = t;
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 0;
    en = 0;
    while (lat < 40) begin
      if (mul_enable[k]) en++;
      if (resp_valid[k]) break;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk(k, "resp_wait", 64'(resp_valid[k]), 64'd1);
    r = resp_result[k];
    f = resp_flags[k];
    tg = resp_tag[k];
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    logic [22:0] m;
    int c;
    c = $urandom_range(0, 9);
    case (c)
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'd1;
      3: e = 8'd254;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic rnd_run(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid[k] = ($urandom_range(0, 2) != 0);
      req_a[k] = rnd_op();
      req_b[k] = rnd_op();
      req_tag[k] = 4'($urandom);
      resp_ready[k] = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    resp_ready[k] = 1'b1;
    repeat (8) @(negedge clk);
    chk(k, "drain_idle", 64'(req_ready[k]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0] f;
    logic [3:0] tg;
    int lat;
    int en;
    logic [31:0] da [5];
    logic [31:0] db [5];
    logic [31:0] dr [5];
    logic [3:0]  df [5];
    int dl [5];

    da = '{32'h40000000, 32'h00000000, 32'h7F800000,
           32'h7F000000, 32'h00800000};
    db = '{32'h40400000, 32'hC0000000, 32'h00000000,
           32'h7F000000, 32'h80800000};
    dr = '{32'h40C00000, 32'h80000000, 32'h7FC00000,
           32'h7F800000, 32'h80000000};
    df = '{4'h0, 4'h1, 4'h4, 4'hA, 4'h9};
    dl = '{2, 0, 0, 2, 2};

    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    resp_ready = 2'b11;

    for (int i = 0; i < 5; i++)
      chk(0, "model_pin", 64'(exp_op(da[i], db[i])),
          64'({dl[i] == 0, df[i], dr[i]}));

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_req_ready", 64'(req_ready[k]), 64'd1);
      chk(k, "rst_resp_valid", 64'(resp_valid[k]), 64'd0);
      chk(k, "rst_mul_enable", 64'(mul_enable[k]), 64'd0);
      chk(k, "rst_mul_a", 64'(mul_a[k]), 64'd0);
      chk(k, "rst_mul_b", 64'(mul_b[k]), 64'd0);
      chk(k, "rst_result", 64'(resp_result[k]), 64'd0);
      chk(k, "rst_flags", 64'(resp_flags[k]), 64'd0);
      chk(k, "rst_tag", 64'(resp_tag[k]), 64'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      go(0, da[i], db[i], 4'(i + 3), lat, en, r, f, tg);
      chk(0, "dir_lat", 64'(lat), 64'(dl[i]));
      chk(0, "dir_en_cycles", 64'(en), 64'(dl[i]));
      chk(0, "dir_result", 64'(r), 64'(dr[i]));
      chk(0, "dir_flags", 64'(f), 64'(df[i]));
      chk(0, "dir_tag", 64'(tg), 64'(i + 3));
      @(negedge clk);
      chk(0, "dir_ready_back", 64'(req_ready[0]), 64'd1);
    end

    resp_ready[0] = 1'b0;
    go(0, 32'h3FC00000, 32'h40000000, 4'hA, lat, en, r, f, tg);
    chk(0, "bp_lat", 64'(lat), 64'd2);
    repeat (5) begin
      @(negedge clk);
      chk(0, "bp_valid", 64'(resp_valid[0]), 64'd1);
      chk(0, "bp_ready", 64'(req_ready[0]), 64'd0);
      chk(0, "bp_result", 64'(resp_result[0]), 64'h40400000);
      chk(0, "bp_flags", 64'(resp_flags[0]), 64'd0);
      chk(0, "bp_tag", 64'(resp_tag[0]), 64'hA);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk(0, "bp_retired", 64'(resp_valid[0]), 64'd0);
    chk(0, "bp_idle", 64'(req_ready[0]), 64'd1);

    req_valid[0] = 1'b1;
    req_a[0] = 32'h3F800000;
    req_b[0] = 32'h40000000;
    req_tag[0] = 4'h1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk(0, "wait_enable", 64'(mul_enable[0]), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk(0, "abort_enable", 64'(mul_enable[0]), 64'd0);
    chk(0, "abort_valid", 64'(resp_valid[0]), 64'd0);
    chk(0, "abort_ready", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(0, "post_rst_valid", 64'(resp_valid[0]), 64'd0);
      chk(0, "post_rst_ready", 64'(req_ready[0]), 64'd1);
    end
    go(0, 32'h3F800000, 32'h3F800000, 4'h2, lat, en, r, f, tg);
    chk(0, "one_result", 64'(r), 64'h3F800000);
    chk(0, "one_flags", 64'(f), 64'd0);
    @(negedge clk);

    rnd_run(0, 800);

    go(1, 32'h40000000, 32'h40400000, 4'h7, lat, en, r, f, tg);
    chk(1, "l3_lat", 64'(lat), 64'd4);
    chk(1, "l3_en_cycles", 64'(en), 64'd4);
    chk(1, "l3_result", 64'(r), 64'h40C00000);
    chk(1, "l3_tag", 64'(tg), 64'h7);
    @(negedge clk);

    rnd_run(1, 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
